wavetable_rd_arbiter: RTL and testbench

//   Shares one synchronous wavetable RAM read port among NREQ DDFS oscillator cores.

---
 rtl/wavetable_rd_arbiter.sv | 155 +++++++++++++++
 tb/tb_wavetable_rd_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/wavetable_rd_arbiter.sv
// wavetable_rd_arbiter
//   Shares one synchronous wavetable RAM read port among NREQ DDFS oscillator
//   cores. One request is granted per cycle (round-robin), the RAM port is
//   driven from registers, and read data is broadcast with a one-hot valid
//   that identifies the owning requester.
//
//   Optional build macro WTARB_FIXED_PRI0_EN:
//     defined   - requester 0 has strict priority; the round-robin pointer
//                 only rotates over requesters 1..NREQ-1.
//     undefined - plain round-robin over 0..NREQ-1.
module wavetable_rd_arbiter #(
  parameter int NREQ   = 4,
  parameter int AW     = 12,
  parameter int DW     = 32,
  parameter int RD_LAT = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NREQ-1:0]           req_rden,
  input  logic [NREQ-1:0][AW-1:0]   req_addr,
  output logic [NREQ-1:0]           req_gnt,
  output logic [AW-1:0]             ram_addr,
  output logic                      ram_rden,
  input  logic [DW-1:0]             ram_q,
  output logic [DW-1:0]             rsp_data,
  output logic [NREQ-1:0]           rsp_valid
);

  localparam int PW = $clog2(NREQ);
  localparam logic [PW-1:0] LAST = PW'(NREQ - 1);
`ifdef WTARB_FIXED_PRI0_EN
  // Pointer ring excludes requester 0, which is served by strict priority.
  localparam logic [PW-1:0] FIRST = PW'(1);
`else
  localparam logic [PW-1:0] FIRST = PW'(0);
`endif

  logic [PW-1:0]   rr_ptr_r;
  logic [PW-1:0]   scan_s;
  logic            hit_s;
  logic            win_vld_s;
  logic [PW-1:0]   win_id_s;
  logic [PW-1:0]   next_ptr_s;
  logic            ptr_upd_s;
  logic [NREQ-1:0] gnt_s;

  logic [AW-1:0]   ram_addr_r;
  logic            ram_rden_r;
  logic [DW-1:0]   rsp_data_r;
  logic [NREQ-1:0] rsp_valid_r;

  // Tag pipeline: {valid, id} travels alongside the RAM read.
  logic [RD_LAT:0] tag_vld_r;
  logic [PW-1:0]   tag_id_r [0:RD_LAT];

  // Arbitration: scan upward from rr_ptr, first active requester wins.
  always_comb begin
    scan_s    = rr_ptr_r;
    hit_s     = 1'b0;
    win_id_s  = '0;
`ifdef WTARB_FIXED_PRI0_EN
    win_vld_s = req_rden[0];
`else
    win_vld_s = 1'b0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      hit_s     = !win_vld_s && req_rden[scan_s];
      win_id_s  = hit_s ? scan_s : win_id_s;
      win_vld_s = win_vld_s | hit_s;
      scan_s    = (scan_s == LAST) ? FIRST : (scan_s + PW'(1));
    end
  end

  // Pointer successor of the winner and whether this grant moves the pointer.
  always_comb begin
    next_ptr_s = (win_id_s == LAST) ? FIRST : (win_id_s + PW'(1));
`ifdef WTARB_FIXED_PRI0_EN
    ptr_upd_s  = win_vld_s && (win_id_s != '0);
`else
    ptr_upd_s  = win_vld_s;
`endif
  end

  // One-hot grant, suppressed while the block is held in reset.
  always_comb begin
    if (reset_n && win_vld_s) begin
      gnt_s = NREQ'(1) << win_id_s;
    end else begin
      gnt_s = '0;
    end
  end

  assign req_gnt = gnt_s;

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_r <= '0;
    end else if (ptr_upd_s) begin
      rr_ptr_r <= next_ptr_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // RAM port issue: registered address/enable of the granted request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_rden_r <= 1'b0;
      ram_addr_r <= '0;
    end else if (win_vld_s) begin
      ram_rden_r <= 1'b1;
      ram_addr_r <= req_addr[win_id_s];
    end else begin
      ram_rden_r <= 1'b0;
      ram_addr_r <= ram_addr_r;
    end
  end

  // Tag shift register aligning the requester id with returning RAM data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_vld_r <= '0;
      for (int i = 0; i <= RD_LAT; i++) begin
        tag_id_r[i] <= '0;
      end
    end else begin
      tag_vld_r   <= {tag_vld_r[RD_LAT-1:0], win_vld_s};
      tag_id_r[0] <= win_id_s;
      for (int i = 1; i <= RD_LAT; i++) begin
        tag_id_r[i] <= tag_id_r[i-1];
      end
    end
  end

  // Response register: capture RAM data and flag its owner for one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_data_r  <= '0;
      rsp_valid_r <= '0;
    end else if (tag_vld_r[RD_LAT]) begin
      rsp_data_r  <= ram_q;
      rsp_valid_r <= NREQ'(1) << tag_id_r[RD_LAT];
    end else begin
      rsp_data_r  <= rsp_data_r;
      rsp_valid_r <= '0;
    end
  end

  assign ram_addr  = ram_addr_r;
  assign ram_rden  = ram_rden_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_valid = rsp_valid_r;

endmodule

// File: tb/tb_wavetable_rd_arbiter.sv
// tb_wavetable_rd_arbiter
//   Directed stimulus with a response scoreboard. Stimulus pushes the expected
//   {rsp_valid, rsp_data} of every grant; a monitor pops and compares whenever
//   rsp_valid is non-zero. RAM model returns {20'h0, addr} after two cycles.
module tb_wavetable_rd_arbiter;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [3:0]        req_rden;
  logic [3:0][11:0]  req_addr;
  logic [3:0]        req_gnt;
  logic [11:0]       ram_addr;
  logic              ram_rden;
  logic [31:0]       ram_q;
  logic [31:0]       ram_s1;
  logic [31:0]       rsp_data;
  logic [3:0]        rsp_valid;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [35:0] exp_q[$];
  logic [35:0] mon_e;
  logic        prev_vld;
  logic [11:0] prev_addr;

  wavetable_rd_arbiter #(.NREQ(4), .AW(12), .DW(32), .RD_LAT(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_rden  (req_rden),
    .req_addr  (req_addr),
    .req_gnt   (req_gnt),
    .ram_addr  (ram_addr),
    .ram_rden  (ram_rden),
    .ram_q     (ram_q),
    .rsp_data  (rsp_data),
    .rsp_valid (rsp_valid)
  );

  always #5 clk = ~clk;

  // Two-cycle synchronous RAM returning {20'h0, addr}.
  always @(posedge clk) begin
    ram_s1 <= ram_rden ? {20'h0, ram_addr} : 32'hDEADBEEF;
    ram_q  <= ram_s1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every response must match the oldest expected one.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && rsp_valid !== 4'b0000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {28'h0, rsp_valid}, 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_valid", {28'h0, rsp_valid}, {28'h0, mon_e[35:32]});
        check("rsp_data", rsp_data, mon_e[31:0]);
      end
    end
  end

  // One cycle of stimulus, entered and left at a falling edge.
  task automatic step(input logic [3:0] rden, input logic [3:0] exp_gnt);
    check("ram_rden", {31'h0, ram_rden}, {31'h0, prev_vld});
    if (prev_vld) check("ram_addr", {20'h0, ram_addr}, {20'h0, prev_addr});
    req_rden = rden;
    #1;
    check("req_gnt", {28'h0, req_gnt}, {28'h0, exp_gnt});
    prev_vld  = (exp_gnt != 4'b0000);
    prev_addr = 12'h000;
    for (int i = 0; i < 4; i++) if (exp_gnt[i]) prev_addr = req_addr[i];
    if (prev_vld) exp_q.push_back({exp_gnt, 20'h0, prev_addr});
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) step(4'b0000, 4'b0000);
    check("queue_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] t2_gnt [8];
    reset_n  = 1'b0;
    req_rden = 4'b1111;
    req_addr = '0;
    prev_vld = 1'b0;
    prev_addr = 12'h000;

    // Reset state, grant forced low even with all requests active.
    repeat (2) @(negedge clk);
    #1;
    check("rst_gnt",      {28'h0, req_gnt},   32'h0);
    check("rst_ram_rden", {31'h0, ram_rden},  32'h0);
    check("rst_ram_addr", {20'h0, ram_addr},  32'h0);
    check("rst_rsp_valid",{28'h0, rsp_valid}, 32'h0);
    check("rst_rsp_data", rsp_data,           32'h0);
    req_rden = 4'b0000;
    @(negedge clk);
    reset_n = 1'b1;

`ifdef WTARB_FIXED_PRI0_EN
    // Requester 0 always wins, then 1,2,3,1 once it drops.
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 4; i++) req_addr[i] = 12'(c * 16 + i);
      step(4'b1111, 4'b0001);
    end
    step(4'b1110, 4'b0010);
    step(4'b1110, 4'b0100);
    step(4'b1110, 4'b1000);
    step(4'b1110, 4'b0010);
`else
    // All four requesting from reset: 0,1,2,3,0,1,2,3.
    t2_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
               4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 4; i++) req_addr[i] = 12'(c * 16 + i);
      step(4'b1111, t2_gnt[c]);
    end
`endif
    drain();

    // Requester 1 present for one cycle while 0 wins, then dropped.
    req_addr[0] = 12'hA00;
    req_addr[1] = 12'hA11;
    step(4'b0011, 4'b0001);
    step(4'b0000, 4'b0000);
    drain();

    // Pointer to 2 via a grant to 1, then 1 and 3 alternate.
    req_addr[1] = 12'h0B1;
    req_addr[3] = 12'h0B3;
    step(4'b0010, 4'b0010);
    step(4'b1010, 4'b1000);
    step(4'b1010, 4'b0010);
    step(4'b1010, 4'b1000);
    step(4'b1010, 4'b0010);
    req_addr[1] = 12'h0C1;
    step(4'b1010, 4'b1000);

    // Single request with exact latency check at t+4.
    req_addr[2] = 12'h123;
    step(4'b0100, 4'b0100);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);
    check("t1_rsp_valid", {28'h0, rsp_valid}, 32'h0000_0004);
    check("t1_rsp_data",  rsp_data,           32'h0000_0123);
    drain();

    // Three grants in flight, asynchronous reset mid-cycle.
    req_addr[3] = 12'hD03;
    req_addr[0] = 12'hD00;
    req_addr[1] = 12'hD01;
    step(4'b1000, 4'b1000);
    step(4'b0001, 4'b0001);
    req_rden = 4'b0010;
    #1;
    check("t4_gnt3", {28'h0, req_gnt}, 32'h0000_0002);
    #2;
    reset_n = 1'b0;
    #1;
    check("t4_rst_gnt",      {28'h0, req_gnt},   32'h0);
    check("t4_rst_ram_rden", {31'h0, ram_rden},  32'h0);
    check("t4_rst_rsp_valid",{28'h0, rsp_valid}, 32'h0);
    exp_q.delete();
    prev_vld = 1'b0;
    req_rden = 4'b0000;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      check("t4_no_rsp", {28'h0, rsp_valid}, 32'h0);
    end
    @(negedge clk);
    req_addr[1] = 12'hE01;
    req_addr[2] = 12'hE02;
    step(4'b0110, 4'b0010);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
